// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and default widths for the UART command sequencer.
package uart_cmd_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 4;
  localparam int ERR_CNT_W_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 4096;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_WAIT = 3'd5
  } cmd_state_e;

  // States in which a received byte is consumed as part of a command.
  function automatic logic is_accepting(input cmd_state_e s);
    return (s == IDLE) || (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

  // States that wait on the register file or transmitter rather than on rx.
  function automatic logic is_busy_wait(input cmd_state_e s);
    return (s == RD_WAIT) || (s == TX_WAIT);
  endfunction

endpackage

// File: rtl/uart_err_counter.sv
// Saturating up-counter: advances on i_inc, sticks at all-ones, cleared only by reset.
module uart_err_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = (r_cnt == '1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// UART command sequencer: decodes AA/BB framed commands into register writes/reads
// and returns read data to the transmitter. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W_DEF,
  parameter int ADDR_WIDTH    = ADDR_W_DEF,
  parameter int ERR_CNT_WIDTH = ERR_CNT_W_DEF,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_data_valid,
  input  logic                     rx_par_err,
  input  logic                     rx_stp_err,
  output logic [ADDR_WIDTH-1:0]    reg_addr,
  output logic [DATA_WIDTH-1:0]    reg_wr_data,
  output logic                     reg_wr_en,
  output logic                     reg_rd_en,
  input  logic [DATA_WIDTH-1:0]    reg_rd_data,
  input  logic                     reg_rd_valid,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_busy,
  output logic                     cmd_busy,
  output logic                     frame_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  cmd_state_e              r_state;
  logic                    r_rx_valid_d;
  logic [ADDR_WIDTH-1:0]   r_reg_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_wr_en;
  logic                    r_rd_en;
  logic                    r_tx_valid;
  logic                    r_cmd_busy;
  logic                    r_frame_err;

  logic                    w_byte_ev;
  logic                    w_rx_bad;
  logic                    w_is_wr;
  logic                    w_is_rd;
  logic                    w_timeout;
  logic                    w_err_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_valid_d <= 1'b0;
    end else begin
      r_rx_valid_d <= rx_data_valid;
    end
  end

  assign w_byte_ev = rx_data_valid & ~r_rx_valid_d;
  assign w_rx_bad  = rx_par_err | rx_stp_err;
  assign w_is_wr   = (rx_data == DATA_WIDTH'(WR_CMD));
  assign w_is_rd   = (rx_data == DATA_WIDTH'(RD_CMD));

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_timed;

  assign w_timed   = (r_state == WR_ADDR) || (r_state == WR_DATA) || (r_state == RD_ADDR);
  assign w_timeout = w_timed && !w_byte_ev && (r_to_cnt == TO_LAST);

  // Untimed states hold the counter at zero, so every timed state is entered with a fresh count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (!w_timed || w_byte_ev || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_err_inc = 1'b0;
    if (w_byte_ev) begin
      if (is_busy_wait(r_state)) begin
        w_err_inc = 1'b1;
      end else if (is_accepting(r_state) && w_rx_bad) begin
        w_err_inc = 1'b1;
      end else if ((r_state == IDLE) && !w_is_wr && !w_is_rd) begin
        w_err_inc = 1'b1;
      end
    end
    if (w_timeout) begin
      w_err_inc = 1'b1;
    end
  end

  // In RD_WAIT/TX_WAIT the byte is only an overrun; completion logic runs regardless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_reg_addr  <= '0;
      r_wr_data   <= '0;
      r_tx_data   <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_cmd_busy  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_frame_err <= w_err_inc;
      case (r_state)
        IDLE: begin
          if (w_byte_ev && !w_rx_bad) begin
            if (w_is_wr) begin
              r_state    <= WR_ADDR;
              r_cmd_busy <= 1'b1;
            end else if (w_is_rd) begin
              r_state    <= RD_ADDR;
              r_cmd_busy <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (w_byte_ev) begin
            if (w_rx_bad) begin
              r_state    <= IDLE;
              r_cmd_busy <= 1'b0;
            end else begin
              r_reg_addr <= rx_data[ADDR_WIDTH-1:0];
              r_state    <= WR_DATA;
            end
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_cmd_busy <= 1'b0;
          end
        end
        WR_DATA: begin
          if (w_byte_ev) begin
            if (!w_rx_bad) begin
              r_wr_data <= rx_data;
              r_wr_en   <= 1'b1;
            end
            r_state    <= IDLE;
            r_cmd_busy <= 1'b0;
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_cmd_busy <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (w_byte_ev) begin
            if (w_rx_bad) begin
              r_state    <= IDLE;
              r_cmd_busy <= 1'b0;
            end else begin
              r_reg_addr <= rx_data[ADDR_WIDTH-1:0];
              r_rd_en    <= 1'b1;
              r_state    <= RD_WAIT;
            end
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_cmd_busy <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (reg_rd_valid) begin
            r_tx_data <= reg_rd_data;
            r_state   <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (!tx_busy) begin
            r_tx_valid <= 1'b1;
            r_state    <= IDLE;
            r_cmd_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cmd_busy <= 1'b0;
        end
      endcase
    end
  end

  uart_err_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_counter (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_inc   (w_err_inc),
    .o_cnt   (err_cnt)
  );

  assign reg_addr      = r_reg_addr;
  assign reg_wr_data   = r_wr_data;
  assign reg_wr_en     = r_wr_en;
  assign reg_rd_en     = r_rd_en;
  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_valid;
  assign cmd_busy      = r_cmd_busy;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl: directed byte streams, expected strobes queued
// by the stimulus and consumed by an independent output monitor.
module tb_uart_rx_cmd_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int EW      = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_data_valid = 1'b0;
  logic          rx_par_err = 1'b0;
  logic          rx_stp_err = 1'b0;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wr_data;
  logic          reg_wr_en;
  logic          reg_rd_en;
  logic [DW-1:0] reg_rd_data = '0;
  logic          reg_rd_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic          tx_busy = 1'b0;
  logic          cmd_busy;
  logic          frame_err;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  uart_rx_cmd_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .ERR_CNT_WIDTH(EW),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_par_err   (rx_par_err),
    .rx_stp_err   (rx_stp_err),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_valid (reg_rd_valid),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_busy      (tx_busy),
    .cmd_busy     (cmd_busy),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  typedef enum int {EV_WR, EV_RD, EV_TX, EV_FE} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [EW-1:0] err;
  } ev_t;

  ev_t           exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            tx_seen = 0;
  int            wr_seen = 0;
  int            exp_err = 0;
  int            rd_delay = 1;
  logic [DW-1:0] rd_val = '0;

  task automatic push(input ev_kind_e k, input int a, input int d);
    ev_t e;
    e.kind = k;
    e.addr = AW'(a);
    e.data = DW'(d);
    if (k == EV_FE && exp_err < ERR_MAX) exp_err++;
    e.err = EW'(exp_err);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic mon(input ev_kind_e k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [EW-1:0] er);
    ev_t e;
    logic ok;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL mon_unexpected: got %s addr=%h data=%h err=%h, required no event",
               k.name(), a, d, er);
    end else begin
      e = exp_q.pop_front();
      ok = (e.kind == k);
      case (k)
        EV_WR: ok = ok && (a === e.addr) && (d === e.data);
        EV_RD: ok = ok && (a === e.addr);
        EV_TX: ok = ok && (d === e.data);
        EV_FE: ok = ok && (er === e.err);
        default: ok = 1'b0;
      endcase
      if (!ok) begin
        bad++;
        $display("FAIL mon_%s: got %s addr=%h data=%h err=%h, required %s addr=%h data=%h err=%h",
                 e.kind.name(), k.name(), a, d, er, e.kind.name(), e.addr, e.data, e.err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_wr_en) begin
        wr_seen++;
        mon(EV_WR, reg_addr, reg_wr_data, err_cnt);
      end
      if (reg_rd_en) mon(EV_RD, reg_addr, reg_wr_data, err_cnt);
      if (tx_data_valid) begin
        tx_seen++;
        mon(EV_TX, reg_addr, tx_data, err_cnt);
      end
      if (frame_err) mon(EV_FE, reg_addr, reg_wr_data, err_cnt);
    end
  end

  // Register-file model: answers each read strobe rd_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && reg_rd_en) begin
        repeat (rd_delay) @(negedge clk);
        reg_rd_valid = 1'b1;
        reg_rd_data  = rd_val;
        @(negedge clk);
        reg_rd_valid = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [DW-1:0] d, input logic par = 1'b0,
                           input logic stp = 1'b0, input int hold = 1);
    rx_data       = d;
    rx_par_err    = par;
    rx_stp_err    = stp;
    rx_data_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_data_valid = 1'b0;
    rx_par_err    = 1'b0;
    rx_stp_err    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    repeat (3) @(negedge clk);
    chk("rst_reg_addr",  reg_addr, 0);
    chk("rst_wr_data",   reg_wr_data, 0);
    chk("rst_wr_en",     reg_wr_en, 0);
    chk("rst_rd_en",     reg_rd_en, 0);
    chk("rst_tx_data",   tx_data, 0);
    chk("rst_tx_valid",  tx_data_valid, 0);
    chk("rst_cmd_busy",  cmd_busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_cnt",   err_cnt, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write AA,03,5C
    push(EV_WR, 3, 8'h5C);
    send_byte(8'hAA);
    chk("wr_busy_mid", cmd_busy, 1);
    send_byte(8'h03);
    send_byte(8'h5C);
    chk("wr_busy_done", cmd_busy, 0);
    chk("wr_err_cnt", err_cnt, 0);
    chk("wr_count", wr_seen, 1);

    // Read BB,07 with transmitter busy for 10 cycles
    rd_val   = 8'h96;
    rd_delay = 1;
    tx_busy  = 1'b1;
    push(EV_RD, 7, 0);
    push(EV_TX, 0, 8'h96);
    send_byte(8'hBB);
    send_byte(8'h07);
    repeat (10) @(negedge clk);
    chk("rd_no_tx_while_busy", tx_seen, 0);
    chk("rd_busy_waiting", cmd_busy, 1);
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_tx_once", tx_seen, 1);
    chk("rd_busy_done", cmd_busy, 0);
    chk("rd_tx_hold", tx_data, 8'h96);

    // Parity error on the address byte, then a clean retry
    wr_before = wr_seen;
    push(EV_FE, 0, 0);
    send_byte(8'hAA);
    send_byte(8'h03, 1'b1);
    chk("par_busy", cmd_busy, 0);
    chk("par_err_cnt", err_cnt, exp_err);
    chk("par_no_write", wr_seen, wr_before);
    push(EV_WR, 3, 8'h11);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h11);
    chk("par_retry_write", wr_seen, wr_before + 1);
    chk("wr_data_hold", reg_wr_data, 8'h11);

    // Overrun: byte 42 held 3 cycles during RD_WAIT
    rd_val   = 8'h3C;
    rd_delay = 10;
    push(EV_RD, 5, 0);
    push(EV_FE, 0, 0);
    push(EV_TX, 0, 8'h3C);
    send_byte(8'hBB);
    send_byte(8'h05);
    send_byte(8'h42, 1'b0, 1'b0, 3);
    repeat (15) @(negedge clk);
    chk("ovr_busy_done", cmd_busy, 0);
    chk("ovr_err_cnt", err_cnt, exp_err);
    chk("ovr_tx_count", tx_seen, 2);
    rd_delay = 1;

`ifdef UART_CMD_TIMEOUT_EN
    push(EV_FE, 0, 0);
    send_byte(8'hAA);
    repeat (20) @(negedge clk);
    chk("to_idle", cmd_busy, 0);
    chk("to_err_cnt", err_cnt, exp_err);
`else
    send_byte(8'hAA);
    repeat (1000) @(negedge clk);
    chk("no_to_still_busy", cmd_busy, 1);
    push(EV_FE, 0, 0);
    send_byte(8'h00, 1'b0, 1'b1);
    chk("stp_abort_idle", cmd_busy, 0);
    chk("stp_err_cnt", err_cnt, exp_err);
`endif

    // Reset in the middle of a write abandons it
    send_byte(8'hAA);
    send_byte(8'h03);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", cmd_busy, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    exp_err = 0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 256 unknown opcodes saturate the error counter
    for (int i = 0; i < 256; i++) begin
      push(EV_FE, 0, 0);
      send_byte(8'h00);
    end
    chk("sat_err_cnt", err_cnt, 8'hFF);
    push(EV_FE, 0, 0);
    send_byte(8'h00);
    chk("sat_hold", err_cnt, 8'hFF);
    chk("sat_idle", cmd_busy, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
